cmos_dvp_tx: RTL

- Transmit side of the CMOS DVP camera interface, producing the signals the capture path consumes: 8-bit data with vsync/href framing.
- Takes RGB565 pixels through a valid/ready handshake, normally from a DDR3 read FIFO, and serialises each pixel as two bytes, high byte first.
- Generates frame and line timing from parameters.
- Used as a camera emulator for loopback tests and as the DVP output for downstream boards.

---
 rtl/cmos_pkg.sv | 41 ++++
 rtl/dvp_timing_gen.sv | 122 ++++++++++++
 rtl/cmos_dvp_tx.sv | 94 +++++++++
 3 files changed

// File: rtl/cmos_pkg.sv
// Shared types and constants for the CMOS DVP transmit path.
//   dvp_state_t : frame FSM states
//   rgb565_t    : RGB565 pixel payload
//   DEF_*       : default 640x480 timing, also used for cmos_tailor settings
package cmos_pkg;

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned R_W    = 5;
    localparam int unsigned G_W    = 6;
    localparam int unsigned B_W    = 5;
    localparam int unsigned VCNT_W = 11;

    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_H_BLANK   = 288;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_VSYNC_LEN = 4;
    localparam int unsigned DEF_V_BACK    = 16;
    localparam int unsigned DEF_V_FRONT   = 8;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } dvp_state_t;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    // Clocks per line: two bytes per active pixel plus blanking.
    function automatic int unsigned line_period(input int unsigned h_active,
                                                input int unsigned h_blank);
        return 2 * h_active + h_blank;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame/line timing for the DVP transmitter.
//   clk, rst_n   : clock, async active-low reset
//   tx_en        : frame enable, sampled in IDLE and at the end of VFRONT
//   req_c        : combinational pixel request (next cycle emits a high byte)
//   start_c      : combinational, next edge starts a frame
//   vsync, href  : registered DVP framing
//   frame_start  : one-cycle pulse with the first vsync cycle
//   frame_done   : one-cycle pulse on the final VFRONT cycle
//   busy         : registered, state != IDLE
module dvp_timing_gen
    import cmos_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_BLANK   = DEF_H_BLANK,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned VSYNC_LEN = DEF_VSYNC_LEN,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned V_FRONT   = DEF_V_FRONT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tx_en,
    output logic req_c,
    output logic start_c,
    output logic vsync,
    output logic href,
    output logic frame_start,
    output logic frame_done,
    output logic busy
);

    localparam int unsigned LP       = line_period(H_ACTIVE, H_BLANK);
    localparam int unsigned HCNT_W   = $clog2(LP);
    localparam int unsigned HREF_END = 2 * H_ACTIVE;

    dvp_state_t          state, state_n;
    logic [HCNT_W-1:0]   hcnt, hcnt_n;
    logic [VCNT_W-1:0]   vcnt, vcnt_n;
    logic [VCNT_W-1:0]   vlast;
    logic                line_end;
    logic                act_n;

    // Next state/counters; registered outputs are decoded from the next
    // values so they line up with the state they describe.
    always_comb begin
        state_n  = state;
        hcnt_n   = hcnt;
        vcnt_n   = vcnt;
        start_c  = 1'b0;
        vlast    = '0;
        line_end = (hcnt == HCNT_W'(LP - 1));

        case (state)
            VSYNC:   vlast = VCNT_W'(VSYNC_LEN - 1);
            VBACK:   vlast = VCNT_W'(V_BACK - 1);
            ACTIVE:  vlast = VCNT_W'(V_ACTIVE - 1);
            VFRONT:  vlast = VCNT_W'(V_FRONT - 1);
            default: vlast = '0;
        endcase

        if (state == IDLE) begin
            if (tx_en) begin
                state_n = VSYNC;
                hcnt_n  = '0;
                vcnt_n  = '0;
                start_c = 1'b1;
            end
        end else if (!line_end) begin
            hcnt_n = hcnt + HCNT_W'(1);
        end else begin
            hcnt_n = '0;
            if (vcnt != vlast) begin
                vcnt_n = vcnt + VCNT_W'(1);
            end else begin
                vcnt_n = '0;
                case (state)
                    VSYNC:  state_n = VBACK;
                    VBACK:  state_n = ACTIVE;
                    ACTIVE: state_n = VFRONT;
                    VFRONT: begin
                        if (tx_en) begin
                            state_n = VSYNC;
                            start_c = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        act_n = (state_n == ACTIVE) && (hcnt_n < HCNT_W'(HREF_END));
        // Request in the cycle before an even (high-byte) href slot.
        req_c = act_n && !hcnt_n[0];
    end

    // State, counters and registered framing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            vsync       <= (state_n == VSYNC);
            href        <= act_n;
            frame_start <= start_c;
            frame_done  <= (state_n == VFRONT) && (hcnt_n == HCNT_W'(LP - 1))
                           && (vcnt_n == VCNT_W'(V_FRONT - 1));
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: rtl/cmos_dvp_tx.sv
// CMOS DVP transmitter: RGB565 pixels in over valid/ready, DVP bytes out
// (high byte first) with vsync/href framing.
//   clk, rst_n          : pixel clock, async active-low reset
//   tx_en               : enables frame generation
//   pix_data, pix_valid : RGB565 source
//   pix_ready           : combinational request; accept when pix_valid=1
//   cam_vsync, cam_href, cam_data : registered DVP outputs
//   frame_start, frame_done       : frame pulses
//   underflow           : sticky missing-pixel flag, cleared at frame start
//   busy                : frame in progress
module cmos_dvp_tx
    import cmos_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_BLANK   = DEF_H_BLANK,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned VSYNC_LEN = DEF_VSYNC_LEN,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned V_FRONT   = DEF_V_FRONT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              cam_vsync,
    output logic              cam_href,
    output logic [BYTE_W-1:0] cam_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic              underflow,
    output logic              busy
);

    logic              req_c;
    logic              start_c;
    logic              take;
    logic              lo_pend;
    logic [BYTE_W-1:0] lo_byte;
    rgb565_t           pix_in;

    assign pix_in    = pix_data;
    assign pix_ready = req_c;
    assign take      = req_c && pix_valid;

    dvp_timing_gen #(
        .H_ACTIVE  (H_ACTIVE),
        .H_BLANK   (H_BLANK),
        .V_ACTIVE  (V_ACTIVE),
        .VSYNC_LEN (VSYNC_LEN),
        .V_BACK    (V_BACK),
        .V_FRONT   (V_FRONT)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_en       (tx_en),
        .req_c       (req_c),
        .start_c     (start_c),
        .vsync       (cam_vsync),
        .href        (cam_href),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    // Byte mux: high byte straight from the accepted pixel, low byte held
    // one cycle. A missed request sends a zero pixel without stalling timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_data  <= '0;
            lo_byte   <= '0;
            lo_pend   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            lo_pend <= req_c;
            if (req_c) begin
                cam_data <= take ? {pix_in.r, pix_in.g[5:3]} : '0;
                lo_byte  <= take ? {pix_in.g[2:0], pix_in.b} : '0;
            end else if (lo_pend) begin
                cam_data <= lo_byte;
            end else begin
                cam_data <= '0;
            end

            if (start_c) begin
                underflow <= 1'b0;
            end else if (req_c && !pix_valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
